reg_file: RTL
=============

# reg_file

Integer register file for the RISC-V pipeline: 32 × 32-bit registers with two combinational read ports for decode and one write port driven by the write-back stage. It also holds a pending-write scoreboard that raises `stall` when decode issues an instruction whose sources are still in flight. It sits between decode (reader, issuer) and write-back (writer).

## Interface
Parameters:
- `XLEN`, 32, register width.
- `NREG`, 32, register count; address width is fixed at 5.

Ports (single clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rs1_addr`  in  5  source 1 address from decode.
- `rs2_addr`  in  5  source 2 address from decode.
- `issue_valid`  in  1  decode presents an instruction this cycle.
- `issue_reg_write`  in  1  the issued instruction writes `issue_rd`.
- `issue_rd`  in  5  destination of the issued instruction.
- `reg_write_wb`  in  1  write enable from write-back.
- `rd_addr_wb`  in  5  write-back destination.
- `data_write_wb`  in  XLEN  write-back data (selected memory/ALU result).
- `read_data1`  out  XLEN  value of `rs1_addr` (combinational).
- `read_data2`  out  XLEN  value of `rs2_addr` (combinational).
- `stall`  out  1  RAW hazard: hold decode this cycle.
- `pending_cnt`  out  6  number of registers with a write in flight.

## Operation
- Storage: `regs[1..31]`. x0 is not stored and always reads 0. Writes to x0 are discarded.
- Write: when `reg_write_wb` is high and `rd_addr_wb` ≠ 0, the clock edge loads `regs[rd_addr_wb]` with `data_write_wb`.
- Read: `read_data1` and `read_data2` are combinational from the array, or from the bypass path (see Configuration).
- Scoreboard: 32-bit `pending` vector. Bit 0 is always 0.
  - Set: if `issue_valid & issue_reg_write & ~stall & issue_rd≠0`, then `pending[issue_rd]` is set to 1.
  - Clear: if `reg_write_wb & rd_addr_wb≠0`, then `pending[rd_addr_wb]` is cleared to 0.
  - Set and clear on the same index in the same cycle: set wins, because the new producer supersedes the old one.
- Hazard: `src_hazard(a)` = `a≠0 & pending[a] & ~clear_now(a)`.
  - `clear_now(a)` = `reg_write_wb & rd_addr_wb==a`, and applies only when bypass is compiled in. Without bypass, `clear_now` is 0.
  - `stall = issue_valid & (src_hazard(rs1_addr) | src_hazard(rs2_addr))`.
  - A stalled issue does not set `pending`.
- `pending_cnt`: a registered population count of `pending`, updated with it. Each cycle it changes by the number of sets minus the number of effective clears, with a net change in the range −1..+1.

## Timing
- Reset (`rst`=1 at an edge): all `regs` = 0, `pending` = 0, `pending_cnt` = 0.
  - After that edge: `read_data1` = `read_data2` = 0 and `stall` = 0.
  - A write-back asserted in the reset cycle is ignored.
- Write latency: data is visible through the array on the cycle after the write edge. With bypass, it is visible in the same cycle.
- `stall` is combinational from the inputs and the current `pending`. It is never asserted when `issue_valid` = 0.
- Scoreboard updates take effect on the edge and affect `stall` from the next cycle onward.
- Back-to-back writes to the same register: the last edge wins. No buffering: one write per cycle.
- `rs1_addr` = `rs2_addr`: both ports return the same value, and the hazard is evaluated once.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
  - Defined: a read whose address equals `rd_addr_wb` (≠0) while `reg_write_wb` = 1 returns `data_write_wb` in the same cycle, and `clear_now` suppresses the stall for that source.
  - Undefined: reads return only the array contents, so a same-cycle write is seen one cycle later, and the stall holds until the `pending` bit clears at the edge.

## Test plan
- Reset then read: assert `rst` 1 cycle; read all 32 addresses → every read returns 0, `stall` = 0, `pending_cnt` = 0.
- x0 protection: WB writes 0xDEADBEEF to x0, then read x0 → 0, and `pending_cnt` is unchanged.
- Write/read: WB writes 0x12345678 to x5; next cycle `rs1_addr` = 5 → 0x12345678.
  - With bypass, in the same cycle `rs2_addr` = 5 → 0x12345678.
  - Without bypass, in the same cycle `rs2_addr` = 5 → the previous value.
- Scoreboard RAW:
  - Issue rd = 7 → `pending_cnt` = 1.
  - Next cycle, issue with rs1 = 7 → `stall` = 1.
  - WB to x7 with value 0xA5 → with bypass, `stall` = 0 in that cycle and `read_data1` = 0xA5; without bypass, `stall` = 0 in the following cycle.
  - `pending_cnt` returns to 0.
- Simultaneous set/clear: x9 is pending; in one cycle, WB writes x9 and a new issue has rd = 9 → `pending[9]` stays 1 and `pending_cnt` is unchanged.
- Reset mid-flight: with x3, x4, x10 pending (`pending_cnt` = 3), assert `rst` together with a WB to x3 → afterward `pending_cnt` = 0, x3 reads 0, and `stall` = 0 for any sources.

Source files
------------

// File: rtl/reg_file.sv
// 32 x XLEN integer register file with two combinational read ports, one write-back port
// and a pending-write scoreboard raising stall on RAW hazards. Optional macro: REGFILE_BYPASS_EN.
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic            issue_valid,
    input  logic            issue_reg_write,
    input  logic [4:0]      issue_rd,
    input  logic            reg_write_wb,
    input  logic [4:0]      rd_addr_wb,
    input  logic [XLEN-1:0] data_write_wb,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    output logic            stall,
    output logic [5:0]      pending_cnt
);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];
    logic [NREG-1:0] pending_q, pending_d;
    logic [5:0]      pending_cnt_q, pending_cnt_d;

    logic wb_fire, set_fire, cnt_inc, cnt_dec;
    logic clear_now1, clear_now2, hazard1, hazard2;

    assign wb_fire = reg_write_wb && (rd_addr_wb != 5'd0);

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (rs1_addr != 5'd0) read_data1 = regs_q[rs1_addr];
        if (rs2_addr != 5'd0) read_data2 = regs_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wb_fire && (rd_addr_wb == rs1_addr)) read_data1 = data_write_wb;
        if (wb_fire && (rd_addr_wb == rs2_addr)) read_data2 = data_write_wb;
`endif
    end

`ifdef REGFILE_BYPASS_EN
    // A source being written back this cycle is already satisfied by the bypass.
    assign clear_now1 = reg_write_wb && (rd_addr_wb == rs1_addr);
    assign clear_now2 = reg_write_wb && (rd_addr_wb == rs2_addr);
`else
    assign clear_now1 = 1'b0;
    assign clear_now2 = 1'b0;
`endif

    assign hazard1  = (rs1_addr != 5'd0) && pending_q[rs1_addr] && !clear_now1;
    assign hazard2  = (rs2_addr != 5'd0) && pending_q[rs2_addr] && !clear_now2;
    assign stall    = issue_valid && (hazard1 || hazard2);
    assign set_fire = issue_valid && issue_reg_write && !stall && (issue_rd != 5'd0);

    always_comb begin
        for (int i = 1; i < NREG; i++) regs_d[i] = regs_q[i];
        if (wb_fire) regs_d[rd_addr_wb] = data_write_wb;
    end

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        pending_d = pending_q;
        if (wb_fire)  pending_d[rd_addr_wb] = 1'b0;
        if (set_fire) pending_d[issue_rd]   = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        cnt_inc = set_fire && !pending_q[issue_rd];
        cnt_dec = wb_fire && pending_q[rd_addr_wb] && !(set_fire && (issue_rd == rd_addr_wb));
        pending_cnt_d = pending_cnt_q + {5'd0, cnt_inc} - {5'd0, cnt_dec};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
            pending_q     <= '0;
            pending_cnt_q <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) regs_q[i] <= regs_d[i];
            pending_q     <= pending_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    assign pending_cnt = pending_cnt_q;

endmodule
